// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID reader: FSM states,
// word addresses and default expected values.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        FINISH
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1511761072;

    function automatic logic verdict(
        input logic [31:0] id,
        input logic [31:0] ts,
        input logic [31:0] exp_id,
        input logic [31:0] exp_ts,
        input logic        check_ts
    );
        return (id == exp_id) && (!check_ts || (ts == exp_ts));
    endfunction

endpackage

// File: rtl/sysid_access_timer.sv
// Per-access waitrequest timeout counter and read-latency counter
// for the system-ID reader.
module sysid_access_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int READ_LATENCY   = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req,
    input  logic lat,
    input  logic waitrequest,
    output logic expired,
    output logic data_valid
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST  =
        2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    logic [15:0] wait_cnt;
    logic [1:0]  lat_cnt;

    // Both counters fall back to zero outside their phase, so each
    // new access (including back-to-back requests) starts fresh.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            wait_cnt <= (req && waitrequest) ? wait_cnt + 16'd1 : '0;
            lat_cnt  <= lat ? lat_cnt + 2'd1 : '0;
        end
    end

    assign expired    = req && waitrequest && (wait_cnt == WAIT_LAST);
    assign data_valid = lat && (lat_cnt == LAT_LAST);

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM read initiator: fetches the system ID and build timestamp,
// latches them and publishes a pass/fail verdict.
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    state_t state;
    logic   auto_pending;
    logic   in_req;
    logic   in_lat;
    logic   expired;
    logic   data_valid;

    assign in_req = (state == REQ_ID) || (state == REQ_TS);
    assign in_lat = (state == LAT_ID) || (state == LAT_TS);

    sysid_access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .READ_LATENCY  (READ_LATENCY)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (in_req),
        .lat        (in_lat),
        .waitrequest(avm_waitrequest),
        .expired    (expired),
        .data_valid (data_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            auto_pending <= AUTO_START;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout_err  <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
            avm_address  <= SYSID_ADDR_ID;
            avm_read     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start || auto_pending) begin
                        auto_pending <= 1'b0;
                        busy         <= 1'b1;
                        pass         <= 1'b0;
                        timeout_err  <= 1'b0;
                        avm_read     <= 1'b1;
                        avm_address  <= SYSID_ADDR_ID;
                        state        <= REQ_ID;
                    end
                end
                REQ_ID: begin
                    if (expired) begin
                        avm_read    <= 1'b0;
                        timeout_err <= 1'b1;
                        pass        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else if (!avm_waitrequest) begin
                        if (READ_LATENCY == 0) begin
                            id_value    <= avm_readdata;
                            avm_address <= SYSID_ADDR_TS;
                            state       <= REQ_TS;
                        end else begin
                            avm_read <= 1'b0;
                            state    <= LAT_ID;
                        end
                    end
                end
                LAT_ID: begin
                    if (data_valid) begin
                        id_value    <= avm_readdata;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_TS;
                        state       <= REQ_TS;
                    end
                end
                REQ_TS: begin
                    if (expired) begin
                        avm_read    <= 1'b0;
                        timeout_err <= 1'b1;
                        pass        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            ts_value <= avm_readdata;
                            pass     <= verdict(id_value, avm_readdata,
                                                EXPECTED_ID, EXPECTED_TS,
                                                CHECK_TS);
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            state <= LAT_TS;
                        end
                    end
                end
                LAT_TS: begin
                    // Verdict uses the incoming word so it is valid with done.
                    if (data_valid) begin
                        ts_value <= avm_readdata;
                        pass     <= verdict(id_value, avm_readdata,
                                            EXPECTED_ID, EXPECTED_TS,
                                            CHECK_TS);
                        done     <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Randomized self-checking bench for sysid_reader: four differently
// configured instances, each against its own Avalon slave model.
module tb_sysid_reader;
    import sysid_pkg::*;

    localparam int N = 4;
    localparam logic [31:0] GOOD_TS = 32'd1511761072;

    function automatic int lat_of(int g);
        case (g)
            1: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int to_of(int g);
        return (g == 2) ? 8 : 255;
    endfunction

    function automatic bit chk_of(int g);
        return (g == 3) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit auto_of(int g);
        return (g == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [31:0] eid_of(int g);
        return (g == 1) ? 32'h1234_5678 : 32'h0000_0000;
    endfunction

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start           [N];
    logic        busy            [N];
    logic        done            [N];
    logic        pass            [N];
    logic        timeout_err     [N];
    logic [31:0] id_value        [N];
    logic [31:0] ts_value        [N];
    logic        avm_address     [N];
    logic        avm_read        [N];
    logic        avm_waitrequest [N];
    logic [31:0] avm_readdata    [N];

    int          stall_cfg [N];
    int          stuck_cfg [N];
    logic [31:0] id_word   [N];
    logic [31:0] ts_word   [N];
    logic [31:0] m_id      [N];
    logic [31:0] m_ts      [N];

    int          busy_tot  [N];
    int          done_tot  [N];
    int          acc0_tot  [N];
    int          acc1_tot  [N];
    logic        pass_at_done [N];
    logic        to_at_done   [N];
    int          rd_cyc    [N];
    int          lat_left  [N];
    logic        last_addr [N];
    logic        pend_addr [N];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        sysid_reader #(
            .EXPECTED_ID   (eid_of(g)),
            .EXPECTED_TS   (GOOD_TS),
            .CHECK_TS      (chk_of(g)),
            .READ_LATENCY  (lat_of(g)),
            .TIMEOUT_CYCLES(to_of(g)),
            .AUTO_START    (auto_of(g))
        ) u_dut (
            .clock          (clock),
            .reset_n        (reset_n),
            .start          (start[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .pass           (pass[g]),
            .timeout_err    (timeout_err[g]),
            .id_value       (id_value[g]),
            .ts_value       (ts_value[g]),
            .avm_address    (avm_address[g]),
            .avm_read       (avm_read[g]),
            .avm_waitrequest(avm_waitrequest[g]),
            .avm_readdata   (avm_readdata[g])
        );
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Slave model and activity monitor, evaluated mid-cycle.
    always @(negedge clock) begin : slave
        logic [31:0] rd;
        logic        w;
        logic        stk;
        for (int g = 0; g < N; g++) begin
            if (!reset_n) begin
                rd_cyc[g]          = 0;
                lat_left[g]        = 0;
                avm_waitrequest[g] = 1'b0;
                avm_readdata[g]    = 32'h0;
            end else begin
                if (busy[g]) busy_tot[g]++;
                if (done[g]) begin
                    done_tot[g]++;
                    pass_at_done[g] = pass[g];
                    to_at_done[g]   = timeout_err[g];
                    check($sformatf("u%0d_read_in_finish", g),
                          32'(avm_read[g]), 32'd0);
                end
                rd = $urandom;
                if (lat_left[g] > 0) begin
                    lat_left[g]--;
                    if (lat_left[g] == 0)
                        rd = pend_addr[g] ? ts_word[g] : id_word[g];
                end
                if (avm_read[g]) begin
                    if (rd_cyc[g] > 0 && avm_waitrequest[g])
                        check($sformatf("u%0d_addr_stable", g),
                              32'(avm_address[g]), 32'(last_addr[g]));
                    if (avm_address[g] !== last_addr[g]) rd_cyc[g] = 0;
                    stk = (stuck_cfg[g] == 1 && !avm_address[g]) ||
                          (stuck_cfg[g] == 2 && avm_address[g]);
                    w = stk || (rd_cyc[g] < stall_cfg[g]);
                    rd_cyc[g]++;
                    last_addr[g] = avm_address[g];
                    if (!w) begin
                        if (avm_address[g]) acc1_tot[g]++;
                        else acc0_tot[g]++;
                        if (lat_of(g) == 0)
                            rd = avm_address[g] ? ts_word[g] : id_word[g];
                        else begin
                            pend_addr[g] = avm_address[g];
                            lat_left[g]  = lat_of(g);
                        end
                    end
                    avm_waitrequest[g] = w;
                end else begin
                    rd_cyc[g]          = 0;
                    avm_waitrequest[g] = 1'b0;
                end
                avm_readdata[g] = rd;
            end
        end
    end

    // One check: kick selects start pulse vs. auto start; extra > 0 pulses
    // start again that many cycles later; stuck 1/2 hangs word 0/1.
    task automatic run(int g, logic [31:0] id, logic [31:0] ts, int stall,
                       int stuck, bit kick, int extra);
        int b0, d0, a0, a1, n, exp_busy, lat, to;
        logic exp_to, exp_pass;
        string t;
        t = $sformatf("u%0d", g);
        id_word[g]   = id;
        ts_word[g]   = ts;
        stall_cfg[g] = stall;
        stuck_cfg[g] = stuck;
        b0 = busy_tot[g];
        d0 = done_tot[g];
        a0 = acc0_tot[g];
        a1 = acc1_tot[g];
        if (kick) begin
            start[g] = 1'b1;
            tick();
            start[g] = 1'b0;
        end
        n = 0;
        while ((done_tot[g] == d0 || n <= extra) && n < 2000) begin
            start[g] = (extra > 0 && n == extra);
            tick();
            n++;
        end
        start[g] = 1'b0;
        check({t, "_done_wait"}, 32'(n < 2000), 32'd1);
        repeat (10) tick();

        lat    = lat_of(g);
        to     = to_of(g);
        exp_to = (stuck != 0);
        if (stuck == 1)      exp_busy = to + 1;
        else if (stuck == 2) exp_busy = (stall + 1 + lat) + to + 1;
        else                 exp_busy = 2 * (stall + 1 + lat) + 1;
        if (stuck != 1) m_id[g] = id;
        if (stuck == 0) m_ts[g] = ts;
        exp_pass = !exp_to && (m_id[g] == eid_of(g)) &&
                   (!chk_of(g) || m_ts[g] == GOOD_TS);

        check({t, "_done_cnt"}, 32'(done_tot[g] - d0), 32'd1);
        check({t, "_pass_at_done"}, 32'(pass_at_done[g]), 32'(exp_pass));
        check({t, "_to_at_done"}, 32'(to_at_done[g]), 32'(exp_to));
        check({t, "_pass"}, 32'(pass[g]), 32'(exp_pass));
        check({t, "_timeout_err"}, 32'(timeout_err[g]), 32'(exp_to));
        check({t, "_id_value"}, id_value[g], m_id[g]);
        check({t, "_ts_value"}, ts_value[g], m_ts[g]);
        check({t, "_busy_cycles"}, 32'(busy_tot[g] - b0), 32'(exp_busy));
        check({t, "_acc_id"}, 32'(acc0_tot[g] - a0), 32'(stuck == 1 ? 0 : 1));
        check({t, "_acc_ts"}, 32'(acc1_tot[g] - a1), 32'(stuck == 0 ? 1 : 0));
        check({t, "_busy_idle"}, 32'(busy[g]), 32'd0);
    endtask

    function automatic logic [31:0] maybe(logic [31:0] good);
        return ($urandom_range(0, 1) != 0) ? good : $urandom;
    endfunction

    initial begin : main
        int n, d0;
        reset_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            start[g]     = 1'b0;
            stall_cfg[g] = 0;
            stuck_cfg[g] = 0;
            id_word[g]   = eid_of(g);
            ts_word[g]   = GOOD_TS;
            m_id[g]      = 32'h0;
            m_ts[g]      = 32'h0;
        end
        repeat (3) tick();
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_pass", 32'(pass[0]), 32'd0);
        check("rst_timeout", 32'(timeout_err[0]), 32'd0);
        check("rst_read", 32'(avm_read[0]), 32'd0);
        check("rst_addr", 32'(avm_address[0]), 32'd0);
        check("rst_id", id_value[0], 32'd0);
        check("rst_ts", ts_value[0], 32'd0);

        reset_n = 1'b1;
        run(0, 32'h0, GOOD_TS, 0, 0, 1'b0, 0);
        run(0, 32'h1, GOOD_TS, 0, 0, 1'b1, 0);
        run(0, 32'h0, GOOD_TS, 1, 0, 1'b1, 1);

        run(1, eid_of(1), GOOD_TS, 3, 0, 1'b1, 0);
        for (int i = 0; i < 6; i++)
            run(1, maybe(eid_of(1)), maybe(GOOD_TS),
                $urandom_range(0, 4), 0, 1'b1, $urandom_range(0, 3));

        run(2, 32'h0, GOOD_TS, 0, 0, 1'b1, 0);
        run(2, 32'h0, 32'hDEAD_BEEF, 1, 2, 1'b1, 0);
        run(2, 32'h5, GOOD_TS, 0, 1, 1'b1, 0);
        run(2, 32'h0, GOOD_TS, 2, 0, 1'b1, 0);

        run(3, 32'h0, 32'h0BAD_0BAD, 0, 0, 1'b1, 2);
        run(3, 32'h7, GOOD_TS, 1, 0, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            run(3, maybe(32'h0), $urandom, $urandom_range(0, 3), 0, 1'b1, 0);

        // Reset in the middle of the timestamp request.
        id_word[0]   = 32'h0;
        ts_word[0]   = GOOD_TS;
        stall_cfg[0] = 2;
        stuck_cfg[0] = 0;
        d0 = done_tot[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n = 0;
        while (!(avm_read[0] && avm_address[0]) && n < 100) begin
            tick();
            n++;
        end
        check("rst_reach_ts", 32'(n < 100), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_read", 32'(avm_read[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_pass", 32'(pass[0]), 32'd0);
        check("midrst_ts", ts_value[0], 32'd0);
        tick();
        tick();
        check("midrst_no_done", 32'(done_tot[0] - d0), 32'd0);
        for (int g = 0; g < N; g++) begin
            m_id[g] = 32'h0;
            m_ts[g] = 32'h0;
        end
        reset_n = 1'b1;
        run(0, 32'h0, GOOD_TS, 2, 0, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysid_reader.md
Name: sysid_reader

Overview:
- Avalon-MM read initiator that queries the system-ID responder at power-up or on demand.
- Reads word 0 (system ID), then word 1 (build timestamp), and compares both against expected values.
- Latches both values and publishes a pass/fail verdict for the Nios-side status logic and the board LEDs.
- Sits on the same interconnect as the sysid slave; one master port and one status interface.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected system-ID word.
- EXPECTED_TS, 32'd1511761072, expected timestamp word.
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp captured only.
- READ_LATENCY, 0, cycles from accepted read (avm_read=1 and avm_waitrequest=0) to valid avm_readdata; legal range 0..3.
- TIMEOUT_CYCLES, 255, maximum cycles waitrequest may stay high per access; legal range 1..65535.
- AUTO_START, 1, 1 = launch one check automatically on the first cycle after reset release.

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to run a check; ignored while busy.
- busy, out, 1, check in progress.
- done, out, 1, one-cycle pulse when a check ends (pass, fail or timeout).
- pass, out, 1, sticky result of the last check.
- timeout_err, out, 1, sticky; last check aborted on timeout.
- id_value, out, 32, last captured system-ID word.
- ts_value, out, 32, last captured timestamp word.
- avm_address, out, 1, word address (0 = ID, 1 = timestamp).
- avm_read, out, 1, read strobe.
- avm_waitrequest, in, 1, slave stall.
- avm_readdata, in, 32, read data.

Behaviour:
Reset (asynchronous, reset_n=0):
- state=IDLE; busy, done, pass, timeout_err, avm_read = 0; avm_address=0; id_value, ts_value = 0; timeout and latency counters = 0.
- A reset mid-access drops avm_read immediately; no result is reported.

States: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FINISH.

IDLE:
- Leaves on start=1, or on the first cycle after reset release when AUTO_START=1.
- Entry to REQ_ID clears pass and timeout_err and sets busy=1.

REQ_ID:
- Drives avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
- On accept: READ_LATENCY=0 captures avm_readdata into id_value in the same cycle and goes to REQ_TS. Otherwise goes to LAT_ID.

LAT_ID:
- avm_read=0; counts READ_LATENCY cycles after accept.
- Captures id_value on the cycle data is valid, then goes to REQ_TS.

REQ_TS / LAT_TS:
- Same as REQ_ID / LAT_ID, with avm_address=1, capturing into ts_value.
- Then go to FINISH.

FINISH (one cycle):
- done=1.
- pass = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS).
- busy=0 on exit; return to IDLE.

Timeout:
- Per-access counter resets on entering each REQ state and increments each cycle waitrequest=1.
- When it reaches TIMEOUT_CYCLES: deassert avm_read, set timeout_err=1, pass=0, go to FINISH.
- The uncaptured value register keeps its previous content.

Other rules:
- No back-to-back overlap: at most one outstanding read.
- avm_read is never asserted in IDLE, LAT_*, or FINISH.
- start asserted while busy is dropped, not queued.
- start in the same cycle as FINISH is dropped; a new check needs start in IDLE.
- Compare is a 32-bit equality; no partial-width checks.

Decomposition:
- Shared package sysid_pkg:
  - state enum;
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - default expected-value constants (also reused by software header generation).
- One sub-module: sysid_access_timer, the per-access waitrequest timeout counter plus read-latency counter, exposing expired and data_valid. FSM and comparison stay in the top.

Test Plan:
- Zero-latency slave returning ID=0, TS=1511761072, AUTO_START=1 -> avm_read seen at address 0 then 1; done pulse; pass=1; id_value=0, ts_value=32'd1511761072; busy back to 0.
- Slave returns ID=32'h0000_0001 -> pass=0, timeout_err=0, id_value=1. Re-run with start and correct ID -> pass=1.
- waitrequest held high 3 cycles per access, READ_LATENCY=2 -> address/read stable while stalled; correct capture; total busy = 2*(3+1+2)+1 cycles.
- waitrequest stuck high, TIMEOUT_CYCLES=8 -> avm_read drops after 8 stall cycles; timeout_err=1, pass=0, done pulse; ts_value unchanged.
- CHECK_TS=0 with wrong TS -> pass=1, ts_value shows wrong value.
- reset_n asserted during REQ_TS, then start pulse while busy -> outputs at reset values, avm_read=0 immediately; after release the extra start is ignored and no second check occurs beyond AUTO_START.
